// File: rtl/accum_arbiter_pkg.sv
// Shared definitions for the accumulator arbiter slice:
// word widths, adder latency and FSM state encodings.
package accum_arbiter_pkg;

  localparam int BIT_LENGTH  = 16;
  localparam int DATA_W_P    = BIT_LENGTH * 2;
  localparam int ACC_LATENCY = 1;
  localparam int DRAIN_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  function automatic logic [DRAIN_W-1:0] drain_load(input int lat);
    return DRAIN_W'(lat - 1);
  endfunction

endpackage

// File: rtl/accum_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or
// after ptr, ascending with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/accum_arbiter.sv
// Round-robin owner of a shared float accumulator: clear,
// stream one burst, wait out adder latency, report the sum.
module accum_arbiter
  import accum_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DATA_W_P,
  parameter int ADD_LATENCY = ACC_LATENCY,
  parameter int ID_W        = 2,
  parameter int CNT_W       = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_sum,
  output logic [CNT_W-1:0]          resp_count,
  output logic                      acc_clr,
  output logic                      acc_add,
  output logic [DATA_W-1:0]         acc_addend,
  input  logic [DATA_W-1:0]         acc_sum
);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [DATA_W-1:0]   rsum_q, rsum_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_id;
  logic                beat_valid;
  logic                beat_last;
  logic [DATA_W-1:0]   beat_data;
  logic                beat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (rr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  always_comb begin
    beat_valid = |(req_valid & gnt_q);
    beat_last  = |(req_last & gnt_q);
    beat_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) beat_data |= req_data[i*DATA_W +: DATA_W];
    end
    beat = (state_q == ST_STREAM) && beat_valid;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gid_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      rid_q   <= '0;
      rsum_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      rid_q   <= rid_d;
      rsum_q  <= rsum_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|req_valid) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_STREAM;
      ST_STREAM: if (beat && beat_last) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_q == '0) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    rid_d   = rid_q;
    rsum_d  = rsum_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          gnt_d = arb_gnt;
          gid_d = arb_id;
        end
      end
      ST_CLEAR: cnt_d = '0;
      ST_STREAM: begin
        if (beat) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (beat_last) drain_d = drain_load(ADD_LATENCY);
        end
      end
      ST_DRAIN: begin
        if (drain_q != '0) drain_d = drain_q - DRAIN_W'(1);
      end
      ST_RESP: begin
        rid_d  = gid_q;
        rsum_d = acc_sum;
        rcnt_d = cnt_q;
        rr_d   = (gid_q == ID_W'(NUM_REQ - 1)) ? '0
                 : gid_q + ID_W'(1);
      end
      default: ;
    endcase
  end

  // Result fields show live values in RESP and hold them afterwards.
  always_comb begin
    req_ready  = (state_q == ST_STREAM) ? gnt_q : '0;
    acc_add    = beat;
    acc_addend = (state_q == ST_STREAM) ? beat_data : '0;
    acc_clr    = (state_q == ST_CLEAR);
    resp_valid = (state_q == ST_RESP);
    resp_id    = resp_valid ? gid_q : rid_q;
    resp_sum   = resp_valid ? acc_sum : rsum_q;
    resp_count = resp_valid ? cnt_q : rcnt_q;
  end

endmodule

// File: tb/tb_accum_arbiter.sv
// Bench for accum_arbiter: float adder model, scoreboard,
// table-driven bursts and hand-written corner sequences.
module tb_accum_arbiter;
  import accum_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int CW = 16;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            resp_valid, acc_clr, acc_add;
  logic [IW-1:0]   resp_id;
  logic [DW-1:0]   resp_sum, acc_addend, acc_sum;
  logic [CW-1:0]   resp_count;

  logic [N-1:0]    v3, l3, ready3;
  logic [N*DW-1:0] d3;
  logic            resp_valid3, acc_clr3, acc_add3;
  logic [IW-1:0]   resp_id3;
  logic [DW-1:0]   resp_sum3, acc_addend3, acc_sum3;
  logic [CW-1:0]   resp_count3;

  accum_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .ADD_LATENCY(1),
    .ID_W(IW), .CNT_W(CW)
  ) u_dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_count(resp_count),
    .acc_clr(acc_clr), .acc_add(acc_add),
    .acc_addend(acc_addend), .acc_sum(acc_sum)
  );

  accum_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .ADD_LATENCY(3),
    .ID_W(IW), .CNT_W(CW)
  ) u_dut3 (
    .Clk(Clk), .Rst(Rst),
    .req_valid(v3), .req_last(l3),
    .req_data(d3), .req_ready(ready3),
    .resp_valid(resp_valid3), .resp_id(resp_id3),
    .resp_sum(resp_sum3), .resp_count(resp_count3),
    .acc_clr(acc_clr3), .acc_add(acc_add3),
    .acc_addend(acc_addend3), .acc_sum(acc_sum3)
  );

  function automatic real b2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return r;
  endfunction

  function automatic logic [31:0] r2b(input real x);
    real r;
    int  e;
    logic [7:0]  eb;
    logic [22:0] m;
    if (x <= 0.0) return 32'h0;
    r = x;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0) begin r = r * 2.0; e--; end
    eb = 8'(e);
    m  = 23'($rtoi((r - 1.0) * 8388608.0));
    return {1'b0, eb, m};
  endfunction

  // Adder models: latency 1 and latency 3 (two-stage input pipe).
  real acc0 = 0.0;
  real acc3 = 0.0;
  logic [1:0]  p3v;
  logic [31:0] p3d0, p3d1;

  always @(posedge Clk) begin
    if (Rst || acc_clr) acc0 <= 0.0;
    else if (acc_add) acc0 <= acc0 + b2r(acc_addend);
  end

  always @(posedge Clk) begin
    if (Rst || acc_clr3) begin
      acc3 <= 0.0;
      p3v  <= 2'b00;
    end else begin
      p3v  <= {p3v[0], acc_add3};
      p3d0 <= acc_addend3;
      p3d1 <= p3d0;
      if (p3v[1]) acc3 <= acc3 + b2r(p3d1);
    end
  end

  assign acc_sum  = r2b(acc0);
  assign acc_sum3 = r2b(acc3);

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] sum;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    int               id;
    int               n;
    logic [3:0][31:0] v;
    logic [31:0]      sum;
    int               cnt;
  } vec_t;

  exp_t sb[$];
  vec_t tbl [4];
  int total = 0;
  int bad = 0;
  int nresp = 0;
  int resp_cyc = 0;
  int clr_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
      chk("add_clr_excl", 32'(acc_add & acc_clr), 0);
      if (acc_clr) clr_cyc = cyc;
      if (resp_valid) begin
        nresp++;
        resp_cyc = cyc;
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("resp_id", 32'(resp_id), 32'(e.id));
          chk("resp_sum", resp_sum, e.sum);
          chk("resp_count", 32'(resp_count), 32'(e.cnt));
        end
      end
    end
  end

  task automatic push(input int id, input logic [31:0] s,
                      input int c);
    exp_t e;
    e.id  = IW'(id);
    e.sum = s;
    e.cnt = CW'(c);
    sb.push_back(e);
  endtask

  // Entered and left just after a rising edge.
  task automatic burst(input int id, input int n,
                       input logic [3:0][31:0] v, input int gap,
                       output int lc);
    int t;
    lc = 0;
    for (int b = 0; b < n; b++) begin
      if (b == 1 && gap > 0) begin
        req_valid[id] = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge Clk);
          chk("stall_add", 32'(acc_add), 0);
          @(posedge Clk);
          #1;
        end
      end
      req_valid[id] = 1'b1;
      req_last[id]  = (b == n - 1);
      req_data[id*DW +: DW] = v[b];
      t = 0;
      @(negedge Clk);
      while (!req_ready[id] && t < 200) begin
        @(negedge Clk);
        t++;
      end
      chk("ready_wait", 32'(t < 200), 1);
      lc = cyc;
      @(posedge Clk);
      #1;
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic wait_resp();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge Clk);
      t++;
    end
    chk("resp_drain", 32'(sb.size()), 0);
    sb.delete();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_rvalid"}, 32'(resp_valid), 0);
    chk({tag, "_add"}, 32'(acc_add), 0);
    chk({tag, "_clr"}, 32'(acc_clr), 0);
    chk({tag, "_rid"}, 32'(resp_id), 0);
    chk({tag, "_rsum"}, resp_sum, 0);
    chk({tag, "_rcnt"}, 32'(resp_count), 0);
    chk({tag, "_addend"}, acc_addend, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lc, lc2, n0, t, bc;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    v3 = '0;
    l3 = '0;
    d3 = '0;
    tbl[0] = '{id:0, n:2,
      v:{32'h0, 32'h0, 32'h40000000, 32'h3F800000},
      sum:32'h40400000, cnt:2};
    tbl[1] = '{id:1, n:1,
      v:{32'h0, 32'h0, 32'h0, 32'h40800000},
      sum:32'h40800000, cnt:1};
    tbl[2] = '{id:2, n:4, v:{4{32'h3F800000}},
      sum:32'h40800000, cnt:4};
    tbl[3] = '{id:3, n:2,
      v:{32'h0, 32'h0, 32'h3E800000, 32'h3F000000},
      sum:32'h3F400000, cnt:2};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_zero("reset");
    chk("reset_rvalid3", 32'(resp_valid3), 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      push(tbl[i].id, tbl[i].sum, tbl[i].cnt);
      burst(tbl[i].id, tbl[i].n, tbl[i].v, 0, lc);
      wait_resp();
      if (i == 0) chk("single_latency", 32'(resp_cyc - lc), 2);
    end

    // Pointer is 0: req1 before req3, leaving the pointer at 0.
    push(1, 32'h40800000, 2);
    push(3, 32'h3F800000, 1);
    fork
      burst(1, 2, {32'h0, 32'h0, 32'h40000000, 32'h40000000}, 0, lc);
      burst(3, 1, {32'h0, 32'h0, 32'h0, 32'h3F800000}, 0, lc2);
    join
    wait_resp();
    push(0, 32'h3F800000, 1);
    push(1, 32'h40000000, 1);
    fork
      burst(0, 1, {32'h0, 32'h0, 32'h0, 32'h3F800000}, 0, lc);
      burst(1, 1, {32'h0, 32'h0, 32'h0, 32'h40000000}, 0, lc2);
    join
    wait_resp();

    push(2, 32'h40400000, 2);
    burst(2, 2, {32'h0, 32'h0, 32'h40000000, 32'h3F800000}, 3, lc);
    wait_resp();

    // Back-to-back bursts from req0, valid kept high between them.
    push(0, 32'h40400000, 2);
    push(0, 32'h40400000, 2);
    burst(0, 2, {32'h0, 32'h0, 32'h40000000, 32'h3F800000}, 0, lc);
    burst(0, 2, {32'h0, 32'h0, 32'h40000000, 32'h3F800000}, 0, lc);
    chk("b2b_idle_gap", 32'(clr_cyc - resp_cyc), 2);
    wait_resp();

    // Reset after one beat of a burst from req1.
    req_valid[1] = 1'b1;
    req_last[1]  = 1'b0;
    req_data[1*DW +: DW] = 32'h3F800000;
    t = 0;
    @(negedge Clk);
    while (!req_ready[1] && t < 200) begin
      @(negedge Clk);
      t++;
    end
    chk("rst_ready_wait", 32'(t < 200), 1);
    @(posedge Clk);
    #1;
    req_valid[1] = 1'b0;
    Rst = 1'b1;
    n0 = nresp;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk_zero("rst_mid");
    repeat (6) @(negedge Clk);
    chk("rst_no_resp", 32'(nresp), 32'(n0));
    @(posedge Clk);
    #1;
    push(3, 32'h40400000, 2);
    burst(3, 2, {32'h0, 32'h0, 32'h40000000, 32'h3F800000}, 0, lc);
    wait_resp();
    chk("rst_resume", 32'(nresp), 32'(n0 + 1));

    // One-beat burst on the latency-3 instance.
    v3[0] = 1'b1;
    l3[0] = 1'b1;
    d3[0 +: DW] = 32'h40A00000;
    t = 0;
    @(negedge Clk);
    while (!ready3[0] && t < 200) begin
      @(negedge Clk);
      t++;
    end
    chk("lat3_ready_wait", 32'(t < 200), 1);
    bc = cyc;
    @(posedge Clk);
    #1;
    v3 = '0;
    l3 = '0;
    t = 0;
    @(negedge Clk);
    while (!resp_valid3 && t < 50) begin
      @(negedge Clk);
      t++;
    end
    chk("lat3_resp_seen", 32'(resp_valid3), 1);
    chk("lat3_latency", 32'(cyc - bc), 4);
    chk("lat3_sum", resp_sum3, 32'h40A00000);
    chk("lat3_count", 32'(resp_count3), 1);
    chk("lat3_id", 32'(resp_id3), 0);

    repeat (3) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_arbiter.md
Name: accum_arbiter

Overview:
- Round-robin scheduler that shares one adderFloat accumulator between NUM_REQ requesters.
- Each requester streams a burst of float addends over a valid/ready handshake, marking the final beat with last.
- The block clears the accumulator, feeds the granted burst, waits out the adder latency, then returns the sum tagged with the requester id.
- Sits between the compute clients and the single adderFloat instance, and is the only driver of that instance's clear and Add inputs.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, `bitLength*2: float word width; matches the adderFloat addend/sum width.
- ADD_LATENCY, 1: cycles from an Add beat until adderFloat sum reflects it (1..4).
- ID_W, 2: requester id width; must be ≥ clog2(NUM_REQ).
- CNT_W, 16: beat counter width.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  final beat of the burst; qualified by valid.
- req_data  in  NUM_REQ*DATA_W  addends; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  beat accepted when valid&ready; one-hot or zero.
- resp_valid  out  1  one-cycle result strobe.
- resp_id  out  ID_W  requester that owns resp_sum.
- resp_sum  out  DATA_W  accumulated float sum.
- resp_count  out  CNT_W  beats accumulated; saturates at all-ones.
- acc_clr  out  1  to adderFloat Rst; the top level ORs it with the system Rst.
- acc_add  out  1  to adderFloat Add.
- acc_addend  out  DATA_W  to adderFloat addend.
- acc_sum  in  DATA_W  from adderFloat sum.

Behaviour:
- Reset (Rst=1 at a clock edge), taking effect in any state:
  - FSM goes to IDLE and the rr pointer goes to 0.
  - req_ready, resp_valid, acc_add and acc_clr are 0; resp_id, resp_sum and resp_count are 0; acc_addend is 0.
  - An in-flight burst is abandoned with no response. Requesters must restart after reset.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, RESP.
- IDLE:
  - If any req_valid is high, grant the first requester at or after the rr pointer, in ascending order with wrap-around. Register grant and go to CLEAR.
  - Otherwise stay in IDLE. A grant decision takes 1 cycle.
- CLEAR: acc_clr=1 for exactly 1 cycle, beat count is set to 0, then go to STREAM.
- STREAM:
  - req_ready[grant]=1; all other ready bits are 0.
  - acc_add = req_valid[grant]; acc_addend = req_data[grant] (combinational pass-through).
  - On each accepted beat, the count increments, saturating at all-ones.
  - If valid drops, the block stalls with acc_add=0; there is no timeout.
  - An accepted beat with last=1 moves the FSM to DRAIN. last without valid is ignored.
- DRAIN: wait ADD_LATENCY cycles using a down-counter, with ready=0 and acc_add=0, then go to RESP.
- RESP (1 cycle):
  - resp_valid=1, resp_sum=acc_sum, resp_id=grant, resp_count=count.
  - rr pointer becomes grant+1, wrapping from NUM_REQ-1 to 0. Go to IDLE.
  - resp_sum, resp_id and resp_count hold their values until the next RESP.
- Timing: request seen at cycle T → acc_clr at T+1 → first ready at T+2. Last beat at L → resp_valid at L+ADD_LATENCY+1.
- acc_add and acc_clr are never high in the same cycle.
- Requests that arrive while busy wait; fairness comes from the rr pointer. A single requester that re-requests immediately regains the grant after one IDLE cycle.
- A one-beat burst (valid&last on the first accepted beat) is legal and gives count=1.

Decomposition:
- Shared package/header (definitions.h): the `bitLength-derived DATA_W, the FSM state encodings, and the ACC_* latency constant.
- One natural sub-module, rr_arbiter:
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded id.
  - Purely combinational; instantiated by accum_arbiter.

Test Plan:
- Single burst: req0 sends 1.0 (0x3F800000) then 2.0 (0x40000000, last) → resp_valid with id=0, sum=0x40400000, count=2. resp_valid fires at L+2 for ADD_LATENCY=1.
- Contention: req1 and req3 both valid at T with pointer=0 → req1 served first, then req3. The pointer ends at 0. Other ready bits stay 0 throughout.
- Stall mid-burst: req2 valid drops for 3 cycles between beats → acc_add=0 during the gap. Final sum is unchanged (0x40400000 for 1.0+2.0) and count=2.
- Back-to-back reuse: two consecutive bursts from req0, each summing to 3.0 → the second result is 0x40400000, not 6.0, which proves acc_clr fires. There is exactly one IDLE cycle between bursts.
- Reset mid-STREAM: Rst=1 for 1 cycle after 1 beat → all outputs 0 the next cycle and no resp_valid. A new burst then completes normally.
- One-beat burst with ADD_LATENCY=3: req0 sends 5.0 (0x40A00000, last) → sum=0x40A00000 and count=1, with resp_valid 4 cycles after the beat.
